// File: rtl/pe_mac_lanes.sv
// pe_mac_lanes: LANES-wide multiply-accumulate PE with first/last window framing,
// saturating accumulation, rounding requantisation, optional ReLU and a ready/valid output.
module pe_mac_lanes #(
  parameter int LANES   = 3,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 8,
  parameter int SIGNED  = 1,
  parameter int SHIFT_W = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [LANES*DATA_W-1:0] ifm,
  input  logic [LANES*DATA_W-1:0] weight,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic                    relu_en,
  output logic [OUT_W-1:0]        ofm,
  output logic                    out_sat,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam bit IS_SIGNED = (SIGNED != 0);
  localparam int PROD_W    = 2 * DATA_W;
  localparam int SUM_W     = PROD_W + $clog2(LANES);
  localparam int EXT_W     = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam int RQ_W      = ACC_W + 2;

  localparam logic signed [EXT_W-1:0] ACC_MAX = IS_SIGNED ?
    {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}} : {{(EXT_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
  localparam logic signed [EXT_W-1:0] ACC_MIN = IS_SIGNED ?
    {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}} : {EXT_W{1'b0}};
  localparam logic signed [RQ_W-1:0] OUT_MAX = IS_SIGNED ?
    {{(RQ_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}} : {{(RQ_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic signed [RQ_W-1:0] OUT_MIN = IS_SIGNED ?
    {{(RQ_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}} : {RQ_W{1'b0}};

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  lane_sum;

  always_comb begin
    lane_sum = '0;
    op_a     = '0;
    op_b     = '0;
    prod     = '0;
    for (int i = 0; i < LANES; i++) begin
      op_a = ifm[i*DATA_W +: DATA_W];
      op_b = weight[i*DATA_W +: DATA_W];
      if (IS_SIGNED) begin
        prod     = PROD_W'($signed(op_a)) * PROD_W'($signed(op_b));
        lane_sum = lane_sum + SUM_W'($signed(prod));
      end else begin
        prod     = PROD_W'(op_a) * PROD_W'(op_b);
        lane_sum = lane_sum + SUM_W'(prod);
      end
    end
  end

  logic               s1_valid;
  logic               s1_first;
  logic               s1_last;
  logic               s1_relu;
  logic [SUM_W-1:0]   s1_sum;
  logic [SHIFT_W-1:0] s1_shift;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_relu  <= 1'b0;
      s1_sum   <= '0;
      s1_shift <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_first <= in_first;
        s1_last  <= in_last;
        s1_relu  <= relu_en;
        s1_sum   <= lane_sum;
        s1_shift <= shift;
      end
    end
  end

  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_next;
  logic signed [EXT_W-1:0] base_ext;
  logic signed [EXT_W-1:0] sum_ext;
  logic signed [EXT_W-1:0] acc_wide;
  logic                    acc_clip;
  logic                    win_sat;
  logic                    win_sat_next;
  logic                    win_relu;
  logic [SHIFT_W-1:0]      win_shift;
  logic [SHIFT_W-1:0]      eff_shift;
  logic                    eff_relu;

  // Accumulate in one spare bit of headroom so the clip test sees the true sum.
  always_comb begin
    if (IS_SIGNED) begin
      base_ext = EXT_W'($signed(acc));
      sum_ext  = EXT_W'($signed(s1_sum));
    end else begin
      base_ext = EXT_W'(acc);
      sum_ext  = EXT_W'(s1_sum);
    end
    if (s1_first) begin
      base_ext = '0;
    end
    acc_wide = base_ext + sum_ext;
    acc_clip = 1'b0;
    acc_next = acc_wide[ACC_W-1:0];
    if (acc_wide > ACC_MAX) begin
      acc_next = ACC_MAX[ACC_W-1:0];
      acc_clip = 1'b1;
    end else if (acc_wide < ACC_MIN) begin
      acc_next = ACC_MIN[ACC_W-1:0];
      acc_clip = 1'b1;
    end
  end

  assign win_sat_next = (win_sat && !s1_first) || acc_clip;
  assign eff_shift    = s1_first ? s1_shift : win_shift;
  assign eff_relu     = s1_first ? s1_relu : win_relu;

  logic               s2_done;
  logic [ACC_W-1:0]   s2_acc;
  logic               s2_sat;
  logic [SHIFT_W-1:0] s2_shift;
  logic               s2_relu;

  // Window state clears on a last beat so a window missing its first beat starts clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      win_sat   <= 1'b0;
      win_shift <= '0;
      win_relu  <= 1'b0;
      s2_done   <= 1'b0;
      s2_acc    <= '0;
      s2_sat    <= 1'b0;
      s2_shift  <= '0;
      s2_relu   <= 1'b0;
    end else if (!stall) begin
      s2_done <= s1_valid && s1_last;
      if (s1_valid) begin
        acc     <= s1_last ? '0 : acc_next;
        win_sat <= s1_last ? 1'b0 : win_sat_next;
        if (s1_first) begin
          win_shift <= s1_shift;
          win_relu  <= s1_relu;
        end
        if (s1_last) begin
          s2_acc   <= acc_next;
          s2_sat   <= win_sat_next;
          s2_shift <= eff_shift;
          s2_relu  <= eff_relu;
        end
      end
    end
  end

  logic signed [RQ_W-1:0] rq_ext;
  logic signed [RQ_W-1:0] rq_round;
  logic signed [RQ_W-1:0] rq_shifted;
  logic [OUT_W-1:0]       rq_out;
  logic                   rq_clip;

  // Shifts at or beyond the accumulator width collapse to the sign fill, bypassing rounding.
  always_comb begin
    if (IS_SIGNED) begin
      rq_ext = RQ_W'($signed(s2_acc));
    end else begin
      rq_ext = RQ_W'(s2_acc);
    end
    rq_round = rq_ext;
    if (s2_shift != '0) begin
      rq_round = rq_ext + (RQ_W'(1) << (s2_shift - SHIFT_W'(1)));
    end
    if (IS_SIGNED) begin
      rq_shifted = rq_round >>> s2_shift;
    end else begin
      rq_shifted = rq_round >> s2_shift;
    end
    if (32'(s2_shift) >= ACC_W) begin
      rq_shifted = (IS_SIGNED && s2_acc[ACC_W-1]) ? '1 : '0;
    end
    if (IS_SIGNED && s2_relu && rq_shifted[RQ_W-1]) begin
      rq_shifted = '0;
    end
    rq_clip = 1'b0;
    rq_out  = rq_shifted[OUT_W-1:0];
    if (rq_shifted > OUT_MAX) begin
      rq_out  = OUT_MAX[OUT_W-1:0];
      rq_clip = 1'b1;
    end else if (rq_shifted < OUT_MIN) begin
      rq_out  = OUT_MIN[OUT_W-1:0];
      rq_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      ofm       <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_done;
      if (s2_done) begin
        ofm     <= rq_out;
        out_sat <= s2_sat || rq_clip;
      end
    end
  end

endmodule
